// File: rtl/beat_timing_gen_pkg.sv
// Shared types and defaults for the CPU timing generator.
// Holds the beat encoding and its one-hot decode.
package cpu_timing_pkg;

  typedef enum logic [1:0] {
    BEAT_W1,
    BEAT_W2,
    BEAT_W3
  } beat_e;

  localparam int DEF_PHASES      = 3;
  localparam int DEF_SYNC_STAGES = 2;

  // Bit 0 is W1, bit 1 is W2, bit 2 is W3.
  function automatic logic [2:0] beat_onehot(beat_e b);
    logic [2:0] oh;
    oh = 3'b001;
    case (b)
      BEAT_W1: oh = 3'b001;
      BEAT_W2: oh = 3'b010;
      BEAT_W3: oh = 3'b100;
      default: oh = 3'b001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/beat_timing_gen_if.sv
// Controller <-> timing generator signal bundle.
// The master is the controller/panel side; the slave is beat_timing_gen.
interface beat_timing_gen_if
  import cpu_timing_pkg::*;
  #(parameter int PHASES = DEF_PHASES);

  logic              qd;
  logic              short;
  logic              long;
  logic              stop;
  logic              step;
  logic [PHASES-1:0] t;
  logic              t3;
  logic              w1;
  logic              w2;
  logic              w3;
  logic              running;
  logic              instr_done;

  modport master (
    output qd, short, long, stop, step,
    input  t, t3, w1, w2, w3, running, instr_done
  );

  modport slave (
    input  qd, short, long, stop, step,
    output t, t3, w1, w2, w3, running, instr_done
  );

endinterface

// File: rtl/beat_timing_gen_button_sync.sv
// Panel button synchroniser with a registered one-clock rising-edge pulse.
// Clear is synchronous and active-low.
module button_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      sync_q <= '0;
      last_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], btn};
      last_q <= sync_q[STAGES-1];
      pulse  <= sync_q[STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/beat_timing_gen.sv
// Beat (W1/W2/W3) and phase (t) generator for the hardwired controller.
// Optional SINGLE_STEP_EN: step=1 halts at each return to W1.
module beat_timing_gen
  import cpu_timing_pkg::*;
  #(
  parameter int PHASES      = DEF_PHASES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               clr,
  beat_timing_gen_if.slave   bus
);

  localparam logic [PHASES-1:0] T_FIRST = {{(PHASES-1){1'b0}}, 1'b1};

  logic              start_pulse;
  logic [PHASES-1:0] t_q;
  beat_e             beat_q;
  beat_e             next_beat;
  logic              running_q;
  logic              done_q;
  logic              halt_req;

  button_sync #(.STAGES(SYNC_STAGES)) u_qd_sync (
    .clk   (clk),
    .clr   (clr),
    .btn   (bus.qd),
    .pulse (start_pulse)
  );

  always_comb begin
    next_beat = BEAT_W1;
    case (beat_q)
      BEAT_W1: next_beat = bus.short ? BEAT_W1 : BEAT_W2;
      BEAT_W2: next_beat = bus.long  ? BEAT_W3 : BEAT_W1;
      default: next_beat = BEAT_W1;
    endcase
  end

`ifdef SINGLE_STEP_EN
  assign halt_req = bus.stop | (bus.step & (next_beat == BEAT_W1));
`else
  logic step_unused;
  assign step_unused = bus.step;
  assign halt_req    = bus.stop;
`endif

  // t_q == 0 while running marks the lead-in cycle after a start edge.
  always_ff @(posedge clk) begin
    if (!clr) begin
      running_q <= 1'b0;
      t_q       <= '0;
      beat_q    <= BEAT_W1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!running_q) begin
        if (start_pulse) running_q <= 1'b1;
      end else if (t_q == '0) begin
        t_q <= T_FIRST;
      end else if (t_q[PHASES-1]) begin
        beat_q <= next_beat;
        done_q <= (next_beat == BEAT_W1);
        if (halt_req) begin
          running_q <= 1'b0;
          t_q       <= '0;
        end else begin
          t_q <= T_FIRST;
        end
      end else begin
        t_q <= t_q << 1;
      end
    end
  end

  assign bus.t                      = t_q;
  assign bus.t3                     = t_q[PHASES-1];
  assign {bus.w3, bus.w2, bus.w1}   = beat_onehot(beat_q);
  assign bus.running                = running_q;
  assign bus.instr_done             = done_q;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Self-checking bench for beat_timing_gen: cycle model plus directed literal checks.
// Build with +define+SINGLE_STEP_EN to exercise the single-step variant.
module tb_beat_timing_gen;
  import cpu_timing_pkg::*;

  localparam int PH = 3;
  localparam int S  = 2;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  beat_timing_gen_if #(.PHASES(PH)) bus();

  beat_timing_gen #(.PHASES(PH), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: running flag, phase index (-1 = none issued), beat number 1..3.
  int m_run  = 0;
  int m_p    = -1;
  int m_beat = 1;
  int m_done = 0;
  bit m_h [S+2];

  always @(posedge clk) begin
    int nb;
    bit edge_seen;
    bit halt;
    if (!clr) begin
      m_run = 0; m_p = -1; m_beat = 1; m_done = 0;
      foreach (m_h[i]) m_h[i] = 1'b0;
    end else begin
      edge_seen = m_h[S] && !m_h[S+1];
      m_done = 0;
      if (m_run == 0) begin
        if (edge_seen) begin m_run = 1; m_p = -1; end
      end else if (m_p < PH-1) begin
        m_p++;
      end else begin
        if (m_beat == 1)      nb = bus.short ? 1 : 2;
        else if (m_beat == 2) nb = bus.long ? 3 : 1;
        else                  nb = 1;
        m_done = (nb == 1);
        m_beat = nb;
        halt = bus.stop;
`ifdef SINGLE_STEP_EN
        if (bus.step && nb == 1) halt = 1'b1;
`endif
        if (halt) begin m_run = 0; m_p = -1; end
        else m_p = 0;
      end
      for (int i = S+1; i > 0; i--) m_h[i] = m_h[i-1];
      m_h[0] = bus.qd;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, got, exp);
    end
  endtask

  // Advance n clocks, comparing every output against the model at each negedge.
  task automatic applyStimulus(input int n);
    logic [PH-1:0] et;
    logic [31:0]   got, exp;
    repeat (n) begin
      @(negedge clk);
      cyc++;
      et  = (m_run != 0 && m_p >= 0) ? PH'(1 << m_p) : '0;
      exp = {23'd0, et, et[PH-1], m_beat == 3, m_beat == 2, m_beat == 1,
             m_run != 0, m_done != 0};
      got = {23'd0, bus.t, bus.t3, bus.w3, bus.w2, bus.w1, bus.running, bus.instr_done};
      checkOutput("cycle_model", got, exp);
    end
  endtask

  int dones;
  bit found;

  initial begin
    bus.qd = 0; bus.short = 0; bus.long = 0; bus.stop = 0; bus.step = 0;
    $display("[TB] start");

    // Reset then idle
    applyStimulus(2);
    clr = 1'b1;
    applyStimulus(10);
    checkOutput("idle_w1", 32'(bus.w1), 32'd1);
    checkOutput("idle_t", 32'(bus.t), 32'd0);
    checkOutput("idle_running", 32'(bus.running), 32'd0);

    // Two-beat instruction
    bus.qd = 1'b1;
    applyStimulus(1);
    bus.qd = 1'b0;
    applyStimulus(2);
    checkOutput("start_not_yet", 32'(bus.running), 32'd0);
    applyStimulus(1);
    checkOutput("start_running", 32'(bus.running), 32'd1);
    checkOutput("start_leadin_t", 32'(bus.t), 32'd0);
    applyStimulus(1);
    checkOutput("w1_t0", 32'({bus.w1, bus.t}), 32'b1_001);
    applyStimulus(2);
    checkOutput("w1_t2", 32'({bus.t3, bus.t}), 32'b1_100);
    applyStimulus(1);
    checkOutput("w2_t0", 32'({bus.w2, bus.t, bus.instr_done}), 32'b1_001_0);
    applyStimulus(3);
    checkOutput("add_done", 32'({bus.w1, bus.t, bus.instr_done}), 32'b1_001_1);

    // Long instruction through W3
    applyStimulus(3);
    bus.long = 1'b1;
    applyStimulus(3);
    checkOutput("w3_t0", 32'({bus.w3, bus.t, bus.instr_done}), 32'b1_001_0);
    bus.long = 1'b0;
    applyStimulus(3);
    checkOutput("long_done", 32'({bus.w1, bus.t, bus.instr_done}), 32'b1_001_1);

    // Console stop between W1 and W2
    applyStimulus(2);
    bus.stop = 1'b1;
    applyStimulus(1);
    bus.stop = 1'b0;
    checkOutput("stop_halt", 32'({bus.w2, bus.running, bus.t}), 32'b1_0_000);
    applyStimulus(20);
    checkOutput("stop_hold", 32'({bus.w2, bus.running, bus.t}), 32'b1_0_000);
    bus.qd = 1'b1;
    applyStimulus(1);
    bus.qd = 1'b0;
    applyStimulus(3);
    checkOutput("resume_running", 32'({bus.running, bus.t}), 32'b1_000);
    applyStimulus(1);
    checkOutput("resume_w2_t0", 32'({bus.w2, bus.t}), 32'b1_001);
    bus.qd = 1'b1;
    applyStimulus(1);
    bus.qd = 1'b0;
    applyStimulus(12);
    checkOutput("qd_while_running", 32'(bus.running), 32'd1);

    // Short instructions, then reset mid-beat
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_run != 0 && m_beat == 1 && m_p == PH-1) found = 1'b1;
      else applyStimulus(1);
    end
    checkOutput("wait_w1_t3", 32'(found), 32'd1);
    bus.short = 1'b1;
    applyStimulus(1);
    checkOutput("short_done1", 32'({bus.w1, bus.t, bus.instr_done}), 32'b1_001_1);
    applyStimulus(3);
    checkOutput("short_done2", 32'({bus.w1, bus.t, bus.instr_done}), 32'b1_001_1);
    applyStimulus(1);
    checkOutput("short_t1", 32'(bus.t), 32'b010);
    clr = 1'b0;
    applyStimulus(1);
    checkOutput("midbeat_reset", 32'({bus.w1, bus.running, bus.t, bus.instr_done}), 32'b1_0_000_0);
    clr = 1'b1;
    bus.short = 1'b0;

    // Single-step request
    applyStimulus(3);
    bus.step = 1'b1;
    bus.qd = 1'b1;
    applyStimulus(1);
    bus.qd = 1'b0;
    applyStimulus(3);
    checkOutput("step_start", 32'(bus.running), 32'd1);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1);
      dones += int'(bus.instr_done);
    end
`ifdef SINGLE_STEP_EN
    checkOutput("step_dones", 32'(dones), 32'd1);
    checkOutput("step_halted", 32'(bus.running), 32'd0);
`else
    checkOutput("step_dones", 32'(dones), 32'd4);
    checkOutput("step_ignored", 32'(bus.running), 32'd1);
`endif
    bus.step = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
